// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - types and helpers shared by the loader and its UART receiver
`include "LoaderDefs.v"

package ram_loader_pkg;

    localparam logic [7:0] HEADER_BYTE = `LD_HEADER;

    typedef enum logic [2:0] {
        ST_IDLE    = `LD_ST_IDLE,
        ST_LEN     = `LD_ST_LEN,
        ST_DATA    = `LD_ST_DATA,
        ST_CSUM    = `LD_ST_CSUM,
        ST_RELEASE = `LD_ST_RELEASE
    } ld_state_e;

    typedef enum logic [1:0] {
        ERR_FRAME    = `LD_ERR_FRAME,
        ERR_LENGTH   = `LD_ERR_LENGTH,
        ERR_CHECKSUM = `LD_ERR_CHECKSUM,
        ERR_TIMEOUT  = `LD_ERR_TIMEOUT
    } ld_err_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // An image must hold at least one byte and fit in RAM.
    function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/LoaderDefs.v
// rtl/LoaderDefs.v - shared protocol constants for the program loader
`ifndef LOADER_DEFS_V
`define LOADER_DEFS_V

`define LD_HEADER        8'hA5

`define LD_ERR_FRAME     2'd0
`define LD_ERR_LENGTH    2'd1
`define LD_ERR_CHECKSUM  2'd2
`define LD_ERR_TIMEOUT   2'd3

`define LD_ST_IDLE       3'd0
`define LD_ST_LEN        3'd1
`define LD_ST_DATA       3'd2
`define LD_ST_CSUM       3'd3
`define LD_ST_RELEASE    3'd4

`endif

// File: rtl/ram_loader_uart_rx.sv
// rtl/ram_loader_uart_rx.sv - 8N1 UART receiver core: synchronizer, bit timer, shift register
module uart_rx_core
    import ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       frame_err_o,
    output logic       start_det_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          valid_q;
    logic          ferr_q;
    logic          start_q;
    logic [7:0]    byte_q;

    // Synchronize the line, time each bit from the start edge and shift in LSB first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            start_q   <= 1'b0;
            byte_q    <= 8'd0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            start_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                        start_q <= 1'b1;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        // A line already back high at mid start bit was only a glitch.
                        if (!rx_sync_q) begin
                            state_q   <= RX_DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            valid_q <= 1'b1;
                            byte_q  <= shift_q;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid_o = valid_q;
    assign rx_byte_o    = byte_q;
    assign frame_err_o  = ferr_q;
    assign start_det_o  = start_q;

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - UART program loader writing RAM and sequencing CPU clear (option: LOADER_TIMEOUT_EN)
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int RAM_LENGTH         = 16,
    parameter int CLKS_PER_BIT       = 104,
    parameter int CLEAR_PULSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES     = 1000000
) (
    input  logic                          i_SYS_CLOCK,
    input  logic                          i_CLEAR_n,
    input  logic                          i_RX,
    output logic                          o_WR_EN,
    output logic [$clog2(RAM_LENGTH)-1:0] o_WR_ADDR,
    output logic [DATA_WIDTH-1:0]         o_WR_DATA,
    output logic                          o_CPU_HOLD,
    output logic                          o_CPU_CLEAR_n,
    output logic                          o_BUSY,
    output logic                          o_DONE,
    output logic                          o_ERROR,
    output logic [1:0]                    o_ERR_CODE
);

    localparam int AW = $clog2(RAM_LENGTH);
    localparam int PW = $clog2(CLEAR_PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(CLEAR_PULSE_CYCLES - 1);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;
    logic       rx_start;
    logic       timeout_hit;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (i_SYS_CLOCK),
        .rst_ni       (i_CLEAR_n),
        .rx_i         (i_RX),
        .byte_valid_o (rx_valid),
        .rx_byte_o    (rx_byte),
        .frame_err_o  (rx_ferr),
        .start_det_o  (rx_start)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q;

    // Inter-byte watchdog: restarts on every start bit while a frame is open.
    always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            to_cnt_q <= '0;
        end else if (!o_BUSY || rx_start) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = o_BUSY && (to_cnt_q == TO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_rx_start;
    assign unused_rx_start = rx_start;
    assign timeout_hit     = 1'b0;
`endif

    ld_state_e     state_q;
    logic [7:0]    len_q;
    logic [7:0]    cnt_q;
    logic [7:0]    csum_q;
    logic [PW-1:0] pulse_q;
    ld_err_e       err_code_q;

    // Protocol FSM: header, length, data writes, checksum and the release pulse.
    always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            state_q       <= ST_IDLE;
            len_q         <= 8'd0;
            cnt_q         <= 8'd0;
            csum_q        <= 8'd0;
            pulse_q       <= '0;
            o_WR_EN       <= 1'b0;
            o_WR_ADDR     <= '0;
            o_WR_DATA     <= '0;
            o_CPU_HOLD    <= 1'b0;
            o_CPU_CLEAR_n <= 1'b1;
            o_BUSY        <= 1'b0;
            o_DONE        <= 1'b0;
            o_ERROR       <= 1'b0;
            err_code_q    <= ERR_FRAME;
        end else begin
            o_WR_EN <= 1'b0;
            if (state_q != ST_IDLE && (rx_ferr || timeout_hit)) begin
                // Failure keeps the CPU held until a later load succeeds.
                state_q       <= ST_IDLE;
                o_BUSY        <= 1'b0;
                o_ERROR       <= 1'b1;
                o_CPU_CLEAR_n <= 1'b1;
                err_code_q    <= rx_ferr ? ERR_FRAME : ERR_TIMEOUT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_valid && rx_byte == HEADER_BYTE) begin
                            o_DONE     <= 1'b0;
                            o_ERROR    <= 1'b0;
                            err_code_q <= ERR_FRAME;
                            o_BUSY     <= 1'b1;
                            o_CPU_HOLD <= 1'b1;
                            cnt_q      <= 8'd0;
                            csum_q     <= 8'd0;
                            state_q    <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            if (len_ok(rx_byte, RAM_LENGTH)) begin
                                len_q   <= rx_byte;
                                state_q <= ST_DATA;
                            end else begin
                                state_q    <= ST_IDLE;
                                o_BUSY     <= 1'b0;
                                o_ERROR    <= 1'b1;
                                err_code_q <= ERR_LENGTH;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rx_valid) begin
                            o_WR_EN   <= 1'b1;
                            o_WR_ADDR <= cnt_q[AW-1:0];
                            o_WR_DATA <= rx_byte;
                            cnt_q     <= cnt_q + 8'd1;
                            csum_q    <= csum_q + rx_byte;
                            if ((cnt_q + 8'd1) == len_q) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (rx_valid) begin
                            if (rx_byte == csum_q) begin
                                state_q       <= ST_RELEASE;
                                o_CPU_CLEAR_n <= 1'b0;
                                pulse_q       <= '0;
                            end else begin
                                state_q    <= ST_IDLE;
                                o_BUSY     <= 1'b0;
                                o_ERROR    <= 1'b1;
                                err_code_q <= ERR_CHECKSUM;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (pulse_q == PULSE_LAST) begin
                            o_CPU_CLEAR_n <= 1'b1;
                            o_CPU_HOLD    <= 1'b0;
                            o_BUSY        <= 1'b0;
                            o_DONE        <= 1'b1;
                            state_q       <= ST_IDLE;
                        end else begin
                            pulse_q <= pulse_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_ERR_CODE = err_code_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - randomized self-checking bench for ram_loader against a protocol model
module tb_ram_loader;

    localparam int CPB   = 16;
    localparam int RL    = 16;
    localparam int PULSE = 4;
    localparam int TO    = 5000;

    typedef logic [7:0] u8_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       cpu_clear_n;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    ram_loader #(
        .DATA_WIDTH         (8),
        .RAM_LENGTH         (RL),
        .CLKS_PER_BIT       (CPB),
        .CLEAR_PULSE_CYCLES (PULSE),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .i_SYS_CLOCK   (clk),
        .i_CLEAR_n     (rst_n),
        .i_RX          (rx),
        .o_WR_EN       (wr_en),
        .o_WR_ADDR     (wr_addr),
        .o_WR_DATA     (wr_data),
        .o_CPU_HOLD    (cpu_hold),
        .o_CPU_CLEAR_n (cpu_clear_n),
        .o_BUSY        (busy),
        .o_DONE        (done),
        .o_ERROR       (error),
        .o_ERR_CODE    (err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed RAM writes and clear-low cycles, accumulated over the whole run.
    int mon_addr[$];
    int mon_data[$];
    int clr_low_total = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(int'(wr_addr));
            mon_data.push_back(int'(wr_data));
        end
        if (!cpu_clear_n) clr_low_total++;
    end

    // Reference model state: outcome of the protocol rules applied byte by byte.
    int m_st, m_len, m_sum, m_n, m_code;
    bit m_done, m_err, m_hold, m_busy;
    int exp_addr[$];
    int exp_data[$];
    int exp_pulse;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_len = 0; m_sum = 0; m_n = 0; m_code = 0;
        m_done = 0; m_err = 0; m_hold = 0; m_busy = 0;
    endtask

    task automatic model_fail(input int code);
        m_err = 1; m_code = code; m_busy = 0; m_st = 0;
    endtask

    task automatic model_byte(input int b, input bit bad_stop);
        if (bad_stop) begin
            if (m_st != 0) model_fail(0);
        end else begin
            case (m_st)
                0: if (b == 'hA5) begin
                    m_done = 0; m_err = 0; m_code = 0; m_hold = 1; m_busy = 1;
                    m_sum = 0; m_n = 0; m_st = 1;
                end
                1: if (b == 0 || b > RL) model_fail(1);
                   else begin m_len = b; m_st = 2; end
                2: begin
                    exp_addr.push_back(m_n);
                    exp_data.push_back(b);
                    m_sum = (m_sum + b) % 256;
                    m_n++;
                    if (m_n == m_len) m_st = 3;
                end
                default: if (b == m_sum) begin
                    m_done = 1; m_hold = 0; m_busy = 0; m_st = 0;
                    exp_pulse += PULSE;
                end else model_fail(2);
            endcase
        end
    endtask

    task automatic send_byte(input u8_t b, input bit bad_stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) rx = !bad_stop;
        repeat (CPB - 1) @(negedge clk);
        @(negedge clk) rx = 1'b1;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int wr_base, input int clr_base);
        int nw;
        nw = mon_addr.size() - wr_base;
        chk({tag, "_nwr"}, nw, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < nw; i++) begin
            chk({tag, "_wa"}, mon_addr[wr_base + i], exp_addr[i]);
            chk({tag, "_wd"}, mon_data[wr_base + i], exp_data[i]);
        end
        chk({tag, "_clrlow"}, clr_low_total - clr_base, exp_pulse);
        chk({tag, "_clr_n"}, cpu_clear_n, 1);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_err"}, error, m_err);
        chk({tag, "_code"}, err_code, m_code);
        chk({tag, "_hold"}, cpu_hold, m_hold);
        chk({tag, "_busy"}, busy, m_busy);
    endtask

    task automatic run_frame(input string tag, input u8_t f[$], input int bad_idx);
        int wb, cb;
        wb = mon_addr.size();
        cb = clr_low_total;
        exp_addr.delete();
        exp_data.delete();
        exp_pulse = 0;
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], i == bad_idx);
            model_byte(int'(f[i]), i == bad_idx);
        end
        repeat (CPB) @(negedge clk);
        check_state(tag, wb, cb);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_clr_n"}, cpu_clear_n, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_code"}, err_code, 0);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    u8_t fq[$];
    u8_t rnd[$];
    int  sum, len, kind, bad;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Abandon a frame with an asynchronous reset in the middle of a byte.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        @(negedge clk) rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (CPB) @(negedge clk);

        fq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame("good3", fq, -1);
        chk("good3_done_fixed", done, 1);

        fq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        run_frame("badsum", fq, -1);
        chk("badsum_code_fixed", err_code, 2);

        fq = {8'hA5, 8'h00};
        run_frame("len0", fq, -1);
        fq = {8'hA5, 8'h11};
        run_frame("len17", fq, -1);
        chk("len17_code_fixed", err_code, 1);

        fq = {8'hA5, 8'h10};
        sum = 0;
        for (int i = 0; i < RL; i++) begin
            fq.push_back(u8_t'($urandom_range(0, 255)));
            sum = (sum + int'(fq[i + 2])) % 256;
        end
        fq.push_back(u8_t'(sum));
        run_frame("full16", fq, -1);
        chk("full16_done_fixed", done, 1);

        // Non-header bytes and a one-cycle glitch must leave a fresh loader untouched.
        do_reset();
        fq = {8'h5A, 8'h00, 8'hFF};
        run_frame("noise", fq, -1);
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_reset_outputs("glitch");

        fq = {8'hA5, 8'h02, 8'hAB};
        run_frame("badstop", fq, 2);
        chk("badstop_code_fixed", err_code, 0);

        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, RL));
            rnd  = {8'hA5};
            if (kind == 2) begin
                rnd.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : u8_t'($urandom_range(RL + 1, 255)));
            end else begin
                rnd.push_back(u8_t'(len));
                sum = 0;
                for (int i = 0; i < len; i++) begin
                    rnd.push_back(u8_t'($urandom_range(0, 255)));
                    sum = (sum + int'(rnd[i + 2])) % 256;
                end
                if (kind == 1) sum = (sum + int'($urandom_range(1, 255))) % 256;
                rnd.push_back(u8_t'(sum));
            end
            bad = -1;
            if (kind == 3) begin
                bad = int'($urandom_range(1, rnd.size() - 1));
                while (rnd.size() > bad + 1) void'(rnd.pop_back());
            end
            run_frame($sformatf("rnd%0d", it), rnd, bad);
        end

        // A stalled frame: the watchdog fires only when it is built in.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
`ifdef LOADER_TIMEOUT_EN
        repeat (TO - 300) @(negedge clk);
        chk("to_early_busy", busy, 1);
        chk("to_early_err", error, 0);
        repeat (300) @(negedge clk);
        chk("to_busy", busy, 0);
        chk("to_err", error, 1);
        chk("to_code", err_code, 3);
        chk("to_hold", cpu_hold, 1);
`else
        repeat (TO + 1000) @(negedge clk);
        chk("stall_busy", busy, 1);
        chk("stall_err", error, 0);
        chk("stall_hold", cpu_hold, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Serial program loader that sits upstream of the CPU's RAM and in front of its clear input.
- Receives a framed program image over a UART line (8N1) and writes it byte-by-byte into RAM through a dedicated write port.
- Holds the CPU in clear for the whole load, then releases it with a clean clear pulse so execution starts at address 0.
- Lets the team reload programs on the board without resynthesis.

Parameters:
- DATA_WIDTH, 8, RAM word width; the protocol requires 8.
- RAM_LENGTH, 16, number of RAM words; maximum accepted image length.
- CLKS_PER_BIT, 104, i_SYS_CLOCK cycles per UART bit; must be ≥ 4.
- CLEAR_PULSE_CYCLES, 4, cycles o_CPU_CLEAR_n is held low after a successful load.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with LOADER_TIMEOUT_EN.

Ports:
- i_SYS_CLOCK  in  1  system clock; the only clock.
- i_CLEAR_n  in  1  reset, asynchronous assert, active-low.
- i_RX  in  1  UART receive line; asynchronous; idles high.
- o_WR_EN  out  1  RAM write strobe, one cycle per data byte.
- o_WR_ADDR  out  $clog2(RAM_LENGTH)  RAM write address.
- o_WR_DATA  out  DATA_WIDTH  RAM write data.
- o_CPU_HOLD  out  1  high while a load is in progress or failed; the CPU must be kept cleared.
- o_CPU_CLEAR_n  out  1  active-low CPU clear request.
- o_BUSY  out  1  load frame in progress.
- o_DONE  out  1  sticky: last load succeeded.
- o_ERROR  out  1  sticky: last load failed.
- o_ERR_CODE  out  2  failure cause, valid when o_ERROR = 1. Encoding: 0 FRAME, 1 LENGTH, 2 CHECKSUM, 3 TIMEOUT.

Behaviour:
- Reset (i_CLEAR_n low, asynchronous):
  - Outputs: o_WR_EN = 0, o_WR_ADDR = 0, o_WR_DATA = 0, o_CPU_HOLD = 0, o_CPU_CLEAR_n = 1, o_BUSY = 0, o_DONE = 0, o_ERROR = 0, o_ERR_CODE = 0.
  - All FSMs return to IDLE; counters clear.
  - Reset mid-load abandons the frame; bytes already written to RAM stay written.
- RX core:
  - i_RX passes through a 2-FF synchronizer; the line is considered high at reset.
  - A falling edge while idle starts a bit timer. At CLKS_PER_BIT/2 the start bit is re-sampled; if it is high, the edge was a glitch and the core returns to idle with no strobe.
  - 8 data bits are sampled LSB first at mid-bit.
  - The stop bit is sampled at mid-bit. The core then emits a one-cycle byte_valid with the byte, or a one-cycle frame_err if the stop bit is 0.
- Protocol (frame = 0xA5, LEN, LEN data bytes, CSUM):
  - IDLE: bytes other than 0xA5 and frame errors are ignored. On 0xA5: clear o_DONE, o_ERROR and o_ERR_CODE; set o_BUSY and o_CPU_HOLD; clear the address and checksum; go to LEN.
  - LEN:
    - LEN = 0 or LEN > RAM_LENGTH: fail with LENGTH.
    - Otherwise latch LEN and go to DATA.
  - DATA:
    - Each byte: on the next cycle, o_WR_EN = 1, o_WR_DATA = byte, o_WR_ADDR = current address.
    - Address increments after the write; checksum += byte mod 256.
    - After LEN bytes, go to CSUM.
    - A 0xA5 here is treated as data.
  - CSUM:
    - Byte == checksum: go to RELEASE.
    - Otherwise fail with CHECKSUM.
  - RELEASE:
    - o_CPU_CLEAR_n is low for exactly CLEAR_PULSE_CYCLES cycles.
    - On the cycle it returns high, o_CPU_HOLD and o_BUSY fall and o_DONE rises; return to IDLE.
  - Fail:
    - A frame_err in any non-IDLE state fails with FRAME.
    - On failure: o_BUSY = 0, o_ERROR = 1, o_ERR_CODE set, o_CPU_HOLD stays 1, state = IDLE.
    - Only a new, successful load releases the CPU.
- Writes never exceed RAM_LENGTH − 1, and the address never wraps.
- o_WR_EN is never asserted outside DATA.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - While o_BUSY = 1, a counter reloads on every RX start-bit detection.
  - If it reaches TIMEOUT_CYCLES, the load fails with TIMEOUT.
- LOADER_TIMEOUT_EN undefined:
  - No counter.
  - A stalled frame keeps o_BUSY high indefinitely; only reset or a completed frame exits.
  - Code 3 never appears.

Decomposition:
- Include file rtl/LoaderDefs.v holds:
  - header value 0xA5
  - ERR_FRAME/LENGTH/CHECKSUM/TIMEOUT codes
  - protocol state encodings
- Sub-module uart_rx_core contains the synchronizer, bit timer and shift register, and outputs byte_valid, byte and frame_err.
- ram_loader holds the protocol FSM, checksum, address counter, clear pulse and timeout.

Test Plan:
- Reset mid-stream, then send A5 03 11 22 33 66 → writes 11@0, 22@1, 33@2; o_CPU_CLEAR_n low 4 cycles; then o_DONE = 1, o_CPU_HOLD = 0.
- Send A5 03 11 22 33 67 → 3 writes occur, then o_ERROR = 1, o_ERR_CODE = 2, o_CPU_HOLD = 1, o_CPU_CLEAR_n never low.
- Send A5 00, then A5 11 → o_ERR_CODE = 1 both times, no writes. Then send a valid 16-byte frame → 16 writes to 0..15, o_DONE = 1.
- Send 5A 00 FF, then a 1-cycle low glitch on i_RX → no state change, no writes, all outputs at reset values.
- Send A5 02 AB with the stop bit forced 0 → o_ERROR = 1, o_ERR_CODE = 0, no write for that byte.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 5000, send A5 02 01 then go silent → o_ERR_CODE = 3 about 5000 cycles after the last start bit. Without the macro → o_BUSY stays 1.
